// File: rtl/a1000_strobe_filter.sv
// rtl/a1000_strobe_filter.sv - A1000 Front-RAM DRAM strobe synchroniser, deglitcher and cycle classifier
// Optional feature macro: STRB_STATS_EN (access/refresh cycle counters)
module a1000_strobe_filter #(
    parameter int FILT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ras_n,
    input  logic        casl0_n,
    input  logic        casu0_n,
    input  logic        casl1_n,
    input  logic        casu1_n,
    input  logic        rrw_n,
    output logic        ras_f_n,
    output logic        casl0_f_n,
    output logic        casu0_f_n,
    output logic        casl1_f_n,
    output logic        casu1_f_n,
    output logic        rrw_f_n,
    output logic        refresh_p,
    output logic        access_p,
    output logic        prot_err,
    output logic [15:0] acc_cnt,
    output logic [15:0] ref_cnt
);

    // Bit order shared by all per-signal vectors: ras, casl0, casu0, casl1, casu1, rrw.
    localparam logic [2:0] FILT_LAST = 3'(FILT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        ACCESS
    } state_t;

    logic [5:0]      raw;
    logic [5:0]      sync1;
    logic [5:0]      sync2;
    logic [5:0]      flt;
    logic [5:0][2:0] cnt;
    state_t          state;
    logic            rrw_q;
    logic            cas;
    logic            end_ref;
    logic            end_acc;

    assign raw = {rrw_n, casu1_n, casl1_n, casu0_n, casl0_n, ras_n};

    assign ras_f_n   = flt[0];
    assign casl0_f_n = flt[1];
    assign casu0_f_n = flt[2];
    assign casl1_f_n = flt[3];
    assign casu1_f_n = flt[4];
    assign rrw_f_n   = flt[5];

    // Any filtered /CAS lane low.
    assign cas = ~(flt[1] & flt[2] & flt[3] & flt[4]);

    // A /RAS cycle ends on the clock the FSM first sees filtered /RAS high.
    assign end_ref = (state == ROW) && flt[0];
    assign end_acc = (state == ACCESS) && flt[0];

    // Two-flop synchroniser; idles high so a released reset looks like negated strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-signal glitch filter: output moves only after FILT consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt <= '1;
            cnt <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == flt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == FILT_LAST) begin
                    flt[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 3'd1;
                end
            end
        end
    end

    // Cycle classifier with registered end-of-cycle pulses and sticky protocol flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            refresh_p <= 1'b0;
            access_p  <= 1'b0;
            prot_err  <= 1'b0;
            rrw_q     <= 1'b1;
        end else begin
            refresh_p <= end_ref;
            access_p  <= end_acc;
            rrw_q     <= flt[5];
            case (state)
                IDLE: begin
                    if (cas && flt[0]) prot_err <= 1'b1;
                    if (!flt[0]) state <= ROW;
                end
                ROW: begin
                    if (flt[0]) begin
                        // First CAS coinciding with RAS release is still a refresh, but suspicious.
                        if (cas) prot_err <= 1'b1;
                        state <= IDLE;
                    end else if (cas) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (flt[0]) begin
                        state <= IDLE;
                    end else if (cas && (flt[5] != rrw_q)) begin
                        prot_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STRB_STATS_EN
    logic [15:0] acc_q;
    logic [15:0] ref_q;

    // Saturating cycle counters, updated together with the registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ref_q <= '0;
        end else begin
            if (end_acc && (acc_q != 16'hFFFF)) acc_q <= acc_q + 16'd1;
            if (end_ref && (ref_q != 16'hFFFF)) ref_q <= ref_q + 16'd1;
        end
    end

    assign acc_cnt = acc_q;
    assign ref_cnt = ref_q;
`else
    assign acc_cnt = 16'h0000;
    assign ref_cnt = 16'h0000;
`endif

endmodule
